// File: rtl/alu16_fsm.sv
// rtl/alu16_fsm.sv - 16-bit multi-function ALU sequenced by a one-op-per-state FSM
// Opcode sampled in IDLE; the matching op state registers its unit's output and returns to IDLE.
module alu16_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        mov_enable,
  input  logic [5:0]  op_code,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  input  logic        cin,
  output logic [15:0] result,
  output logic [15:0] remainder,
  output logic        bout,
  output logic        busy
);

  // State encodings equal their opcodes so IDLE can dispatch with a direct cast.
  typedef enum logic [5:0] {
    S_IDLE = 6'h00, S_ADD = 6'h01, S_SUB = 6'h02, S_INC = 6'h03,
    S_DEC  = 6'h04, S_MOD = 6'h05, S_AND = 6'h06, S_MOV = 6'h08,
    S_NOT  = 6'h09, S_OR  = 6'h0A, S_XOR = 6'h0B, S_MUL = 6'h0C,
    S_LSL  = 6'h0D, S_LSR = 6'h0E, S_RSL = 6'h0F, S_RSR = 6'h10,
    S_DIV  = 6'h11
  } state_t;

  state_t      r_state;
  logic [15:0] r_result;
  logic [15:0] r_remainder;
  logic        r_bout;

  logic        w_legal;
  logic [15:0] w_add;
  logic [16:0] w_sub;
  logic [15:0] w_mul;
  logic [15:0] w_quot;
  logic [15:0] w_rem;
  logic [15:0] w_lsl;
  logic [15:0] w_lsr;
  logic [15:0] w_rol;
  logic [15:0] w_ror;

  assign w_legal = (op_code != 6'h00) && (op_code != 6'h07) && (op_code <= 6'h11);

  assign w_add  = a + b + {15'd0, cin};
  // Bit 16 of the widened difference is the borrow-out.
  assign w_sub  = {1'b0, a} - {1'b0, b} - {16'd0, bin};
  assign w_mul  = a * b;
  assign w_quot = (b == 16'd0) ? 16'hFFFF : a / b;
  assign w_rem  = (b == 16'd0) ? a : a % b;
  assign w_lsl  = (b > 16'd15) ? 16'd0 : (a << b[3:0]);
  assign w_lsr  = (b > 16'd15) ? 16'd0 : (a >> b[3:0]);
  assign w_rol  = (a << b[3:0]) | (a >> (5'd16 - {1'b0, b[3:0]}));
  assign w_ror  = (a >> b[3:0]) | (a << (5'd16 - {1'b0, b[3:0]}));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_result    <= 16'd0;
      r_remainder <= 16'd0;
      r_bout      <= 1'b0;
    end else begin
      r_state <= S_IDLE;
      case (r_state)
        S_IDLE: if (w_legal) r_state <= state_t'(op_code);
        S_ADD:  r_result <= w_add;
        S_SUB:  begin r_result <= w_sub[15:0]; r_bout <= w_sub[16]; end
        S_INC:  r_result <= a + 16'd1;
        S_DEC:  r_result <= a - 16'd1;
        S_MOD:  r_result <= w_rem;
        S_AND:  r_result <= a & b;
        S_MOV:  if (mov_enable) r_result <= a;
        S_NOT:  r_result <= ~a;
        S_OR:   r_result <= a | b;
        S_XOR:  r_result <= a ^ b;
        S_MUL:  r_result <= w_mul;
        S_LSL:  r_result <= w_lsl;
        S_LSR:  r_result <= w_lsr;
        S_RSL:  r_result <= w_rol;
        S_RSR:  r_result <= w_ror;
        S_DIV:  begin r_result <= w_quot; r_remainder <= w_rem; end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result    = r_result;
  assign remainder = r_remainder;
  assign bout      = r_bout;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu16_fsm.sv
// tb/tb_alu16_fsm.sv - directed-vector self-checking bench for alu16_fsm
module tb_alu16_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        mov_enable;
  logic [5:0]  op_code;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        cin;
  logic [15:0] result;
  logic [15:0] remainder;
  logic        bout;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  alu16_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .mov_enable (mov_enable),
    .op_code    (op_code),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .cin        (cin),
    .result     (result),
    .remainder  (remainder),
    .bout       (bout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; holds the opcode 4 cycles (two executions), then idles one cycle.
  task automatic do_op(input logic [5:0] op, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ic, input logic ibn, input logic imov);
    op_code = op; a = ia; b = ib; cin = ic; bin = ibn; mov_enable = imov;
    repeat (4) @(posedge clk);
    @(negedge clk);
    op_code = 6'h00;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; op_code = 6'h00; a = 16'd0; b = 16'd0;
    cin = 1'b0; bin = 1'b0; mov_enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_result", result, 16'h0000);
    check("rst_rem", remainder, 16'h0000);
    check("rst_bout", {15'd0, bout}, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'h0000);

    do_op(6'h01, 16'd10, 16'd5, 1'b0, 1'b0, 1'b0);  check("add", result, 16'd15);
    do_op(6'h02, 16'd15, 16'd5, 1'b0, 1'b0, 1'b0);  check("sub", result, 16'd10);
    check("sub_bout", {15'd0, bout}, 16'd0);
    do_op(6'h03, 16'd10, 16'd0, 1'b0, 1'b0, 1'b0);  check("inc", result, 16'd11);
    do_op(6'h04, 16'd10, 16'd0, 1'b0, 1'b0, 1'b0);  check("dec", result, 16'd9);
    do_op(6'h05, 16'd10, 16'd3, 1'b0, 1'b0, 1'b0);  check("mod", result, 16'd1);
    check("mod_rem_hold", remainder, 16'd0);
    do_op(6'h06, 16'd15, 16'd7, 1'b0, 1'b0, 1'b0);  check("and", result, 16'd7);
    do_op(6'h0A, 16'd15, 16'd7, 1'b0, 1'b0, 1'b0);  check("or", result, 16'd15);
    do_op(6'h0B, 16'd15, 16'd7, 1'b0, 1'b0, 1'b0);  check("xor", result, 16'd8);
    do_op(6'h09, 16'd10, 16'd0, 1'b0, 1'b0, 1'b0);  check("not", result, 16'hFFF5);
    do_op(6'h0C, 16'd10, 16'd5, 1'b0, 1'b0, 1'b0);  check("mul", result, 16'd50);
    do_op(6'h11, 16'd15, 16'd7, 1'b0, 1'b0, 1'b0);  check("div_q", result, 16'd2);
    check("div_r", remainder, 16'd1);
    do_op(6'h11, 16'd9, 16'd0, 1'b0, 1'b0, 1'b0);   check("div0_q", result, 16'hFFFF);
    check("div0_r", remainder, 16'd9);
    do_op(6'h05, 16'd9, 16'd0, 1'b0, 1'b0, 1'b0);   check("mod0", result, 16'd9);
    do_op(6'h0D, 16'd10, 16'd3, 1'b0, 1'b0, 1'b0);  check("lsl", result, 16'd80);
    do_op(6'h0E, 16'd10, 16'd3, 1'b0, 1'b0, 1'b0);  check("lsr", result, 16'd1);
    do_op(6'h0F, 16'd10, 16'd3, 1'b0, 1'b0, 1'b0);  check("rsl", result, 16'd80);
    do_op(6'h10, 16'd10, 16'd3, 1'b0, 1'b0, 1'b0);  check("rsr", result, 16'd16385);
    do_op(6'h0D, 16'd10, 16'd16, 1'b0, 1'b0, 1'b0); check("lsl16", result, 16'd0);
    do_op(6'h01, 16'hFFFF, 16'd0, 1'b1, 1'b0, 1'b0); check("add_cin_wrap", result, 16'd0);
    do_op(6'h08, 16'd5, 16'd0, 1'b0, 1'b0, 1'b1);   check("mov_en", result, 16'd5);
    do_op(6'h08, 16'd7, 16'd0, 1'b0, 1'b0, 1'b0);   check("mov_dis", result, 16'd5);
    do_op(6'h04, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);   check("dec0", result, 16'hFFFF);
    do_op(6'h02, 16'd0, 16'd1, 1'b0, 1'b0, 1'b0);   check("sub_borrow", result, 16'hFFFF);
    check("sub_bout1", {15'd0, bout}, 16'd1);
    check("sub_rem_hold", remainder, 16'd9);
    do_op(6'h03, 16'd10, 16'd0, 1'b0, 1'b0, 1'b0);  check("inc2", result, 16'd11);
    check("inc_bout_hold", {15'd0, bout}, 16'd1);

    op_code = 6'h07; a = 16'h1234; b = 16'h0003;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nop07_busy", {15'd0, busy}, 16'd0);
    end
    check("nop07_result", result, 16'd11);
    check("nop07_rem", remainder, 16'd9);
    op_code = 6'h00;

    @(negedge clk);
    op_code = 6'h01; a = 16'd1; b = 16'd1; cin = 1'b0;
    @(negedge clk); check("busy_t1", {15'd0, busy}, 16'd1);
    @(negedge clk); check("busy_t2", {15'd0, busy}, 16'd0);
    @(negedge clk); check("busy_t3", {15'd0, busy}, 16'd1);
    @(negedge clk); check("busy_t4", {15'd0, busy}, 16'd0);
    op_code = 6'h00;
    check("busy_t_result", result, 16'd2);

    @(negedge clk);
    op_code = 6'h11; a = 16'd40; b = 16'd0;
    @(negedge clk); check("rst_op_busy", {15'd0, busy}, 16'd1);
    rst = 1'b1; op_code = 6'h00;
    @(negedge clk);
    check("rst_op_result", result, 16'd0);
    check("rst_op_rem", remainder, 16'd0);
    check("rst_op_bout", {15'd0, bout}, 16'd0);
    check("rst_op_busy0", {15'd0, busy}, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_result", result, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
